// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multicycle fetch/decode/exec/mem/writeback controller driving the ALU command port.
// Optional build macro CPU_CTRL_MEM_TIMEOUT_EN adds a memory-wait watchdog with a sticky fault and HALT state.
module cpu_control_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_data_in,
    input  logic        dmem_ack_in,
    input  logic [3:0]  alu_nzcv_in,
    output logic        imem_req_out,
    output logic [31:0] pc_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [3:0]  alu_cmd_out,
    output logic        alu_imm_sel_out,
    output logic [31:0] imm_out,
    output logic [3:0]  rn_out,
    output logic [3:0]  rd_out,
    output logic        reg_we_out,
    output logic [3:0]  flags_out,
    output logic        fault_out
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, br_target;
    logic [3:0]  flags_q, flags_d;
    logic        is_dp, is_ls, is_br, is_test, cond_pass, flag_upd;
    logic        nf, zf, cf, vf;
    assign {nf, zf, cf, vf} = flags_q;
    assign is_dp     = ir_q[27:26] == 2'b00;
    assign is_ls     = ir_q[27:26] == 2'b01;
    assign is_br     = ir_q[27:26] == 2'b10;
    assign is_test   = ir_q[24:23] == 2'b10;
    assign flag_upd  = is_dp && (ir_q[20] || is_test);
    assign br_target = pc_q + 32'd4 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
    // Condition code evaluation against the latched flags; 1111 never executes
    always_comb begin
        cond_pass = 1'b0;
        case (ir_q[31:28])
            4'h0: cond_pass = zf;
            4'h1: cond_pass = !zf;
            4'h2: cond_pass = cf;
            4'h3: cond_pass = !cf;
            4'h4: cond_pass = nf;
            4'h5: cond_pass = !nf;
            4'h6: cond_pass = vf;
            4'h7: cond_pass = !vf;
            4'h8: cond_pass = cf && !zf;
            4'h9: cond_pass = !cf || zf;
            4'hA: cond_pass = nf == vf;
            4'hB: cond_pass = nf != vf;
            4'hC: cond_pass = !zf && (nf == vf);
            4'hD: cond_pass = zf || (nf != vf);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d, wait_ack, timeout_hit;
    assign wait_ack    = (state_q == S_FETCH && !imem_ack_in) || (state_q == S_MEM && !dmem_ack_in);
    assign timeout_hit = wait_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign cnt_d       = wait_ack ? cnt_q + 1'b1 : '0;
    assign fault_d     = fault_q || timeout_hit;
    assign fault_out   = fault_q;
    // Watchdog counter and sticky fault flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
`else
    assign fault_out = 1'b0;
`endif
    // Next-state, PC, instruction and flag update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack_in) begin
                    ir_d    = imem_data_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cond_pass && ir_q[27:26] != 2'b11) state_d = S_EXEC;
                else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                flags_d = flag_upd ? alu_nzcv_in : flags_q;
                pc_d    = is_br ? br_target : pc_q;
                state_d = is_br ? S_FETCH : is_dp ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (dmem_ack_in) begin
                    pc_d    = ir_q[20] ? pc_q : pc_q + 32'd4;
                    state_d = ir_q[20] ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                pc_d    = pc_q + 32'd4;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        if (timeout_hit) state_d = S_HALT;
`endif
    end
    // Architectural state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end
    assign imem_req_out    = state_q == S_FETCH;
    assign dmem_req_out    = state_q == S_MEM;
    assign dmem_we_out     = state_q == S_MEM && !ir_q[20];
    assign alu_cmd_out     = (state_q == S_EXEC && is_dp) ? ir_q[24:21] :
                             ((state_q == S_EXEC && is_ls) || state_q == S_MEM) ? 4'b0100 : 4'b0000;
    assign alu_imm_sel_out = (state_q == S_EXEC && (is_dp ? ir_q[25] : is_ls)) || state_q == S_MEM;
    assign reg_we_out      = state_q == S_WB && !(is_dp && is_test);
    assign pc_out          = pc_q;
    assign flags_out       = flags_q;
    assign imm_out         = {20'd0, ir_q[11:0]};
    assign rn_out          = ir_q[19:16];
    assign rd_out          = ir_q[15:12];
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: randomized instruction stream checked against an instruction-level reference model.
module tb_cpu_control_fsm;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_ack_in = 1'b0, dmem_ack_in = 1'b0;
    logic [31:0] imem_data_in = '0;
    logic [3:0]  alu_nzcv_in = '0;
    logic        imem_req_out, dmem_req_out, dmem_we_out, alu_imm_sel_out, reg_we_out, fault_out;
    logic [31:0] pc_out, imm_out;
    logic [3:0]  alu_cmd_out, rn_out, rd_out, flags_out;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset),
        .imem_ack_in(imem_ack_in), .imem_data_in(imem_data_in),
        .dmem_ack_in(dmem_ack_in), .alu_nzcv_in(alu_nzcv_in),
        .imem_req_out(imem_req_out), .pc_out(pc_out),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .alu_cmd_out(alu_cmd_out), .alu_imm_sel_out(alu_imm_sel_out),
        .imm_out(imm_out), .rn_out(rn_out), .rd_out(rd_out),
        .reg_we_out(reg_we_out), .flags_out(flags_out), .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ARM condition table expressed as base predicate plus inversion bit
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        {n, z, cy, v} = f;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = n == v;
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] nz, input int dd, input int fdly);
        int unsigned op, cmd, exp_cyc, exp_we, exp_dm;
        int          cyc = 0, we_cnt = 0, dm_cnt = 0, dm_bad = 0;
        logic [3:0]  rd_seen = '0;
        logic signed [31:0] off;
        bit          pass, test;
        op   = ins[27:26];
        cmd  = ins[24:21];
        test = cmd >= 8 && cmd <= 11;
        pass = cond_ok(ins[31:28], m_flags) && op != 3;
        chk("fetch_req", imem_req_out, 1);
        chk("pc", pc_out, m_pc);
        chk("flags", flags_out, m_flags);
        chk("fault_idle", fault_out, 0);
        repeat (fdly) begin
            @(negedge clk);
            chk("fetch_hold", imem_req_out, 1);
        end
        imem_ack_in  = 1'b1;
        imem_data_in = ins;
        alu_nzcv_in  = nz;
        @(negedge clk);
        while (!imem_req_out && cyc < 40) begin
            cyc++;
            if (cyc == 1) begin
                chk("imm", imm_out, {20'd0, ins[11:0]});
                chk("rn", rn_out, ins[19:16]);
                chk("decode_cmd", alu_cmd_out, 0);
            end
            if (cyc == 2 && pass && op == 0) begin
                chk("exec_cmd", alu_cmd_out, cmd);
                chk("exec_isel", alu_imm_sel_out, ins[25]);
            end
            if (cyc == 2 && pass && op == 1) begin
                chk("exec_cmd_ls", alu_cmd_out, 4'b0100);
                chk("exec_isel_ls", alu_imm_sel_out, 1);
            end
            if (reg_we_out) begin
                we_cnt++;
                rd_seen = rd_out;
            end
            if (dmem_req_out) begin
                dm_cnt++;
                if (dmem_we_out !== !ins[20] || alu_cmd_out !== 4'b0100) dm_bad++;
            end
            dmem_ack_in  = dmem_req_out && dm_cnt == dd + 1;
            imem_ack_in  = ($urandom % 4) == 0;
            imem_data_in = $urandom;
            @(negedge clk);
        end
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        exp_cyc = !pass ? 1 : op == 2 ? 2 : op == 0 ? 3 : (ins[20] ? 3 : 2) + dd + 1;
        exp_we  = (pass && ((op == 0 && !test) || (op == 1 && ins[20]))) ? 1 : 0;
        exp_dm  = (pass && op == 1) ? dd + 1 : 0;
        chk("latency", cyc, exp_cyc);
        chk("reg_we_count", we_cnt, exp_we);
        if (exp_we == 1) chk("rd", rd_seen, ins[15:12]);
        chk("dmem_cycles", dm_cnt, exp_dm);
        chk("mem_phase_bad", dm_bad, 0);
        if (pass && op == 0 && (ins[20] || test)) m_flags = nz;
        off  = $signed(ins[23:0]);
        m_pc = (pass && op == 2) ? m_pc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
    endtask

    task automatic rand_instr();
        logic [31:0] ins = $urandom;
        if ($urandom % 3 == 0) ins[31:28] = 4'hE;
        run_instr(ins, 4'($urandom), int'($urandom % 4), int'($urandom % 3));
    endtask

    logic [31:0] d_ins [6] = '{32'hE0900002, 32'h1A000003, 32'hE1500001, 32'hBA000002, 32'hE5910004, 32'hE5810004};
    logic [3:0]  d_nz  [6] = '{4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    int          d_dd  [6] = '{0, 0, 0, 0, 3, 1};

    initial begin
        int n;
        m_pc    = 32'h0;
        m_flags = 4'h0;
        @(negedge clk);
        chk("rst_pc", pc_out, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_dmem_req", dmem_req_out, 0);
        chk("rst_alu_cmd", alu_cmd_out, 0);
        chk("rst_reg_we", reg_we_out, 0);
        chk("rst_fault", fault_out, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run_instr(d_ins[i], d_nz[i], d_dd[i], i == 0 ? 2 : 0);
        for (int i = 0; i < 150; i++) rand_instr();
        imem_ack_in  = 1'b1;
        imem_data_in = 32'hE5910004;
        @(negedge clk);
        imem_ack_in = 1'b0;
        n = 0;
        while (!dmem_req_out && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("reach_mem", dmem_req_out, 1);
        reset = 1'b1;
        #1;
        chk("async_dmem_req", dmem_req_out, 0);
        chk("async_pc", pc_out, 0);
        chk("async_flags", flags_out, 0);
        chk("async_rd", rd_out, 0);
        chk("async_fetch", imem_req_out, 1);
        @(negedge clk);
        reset   = 1'b0;
        m_pc    = 32'h0;
        m_flags = 4'h0;
        for (int i = 0; i < 20; i++) rand_instr();
`ifdef CPU_CTRL_MEM_TIMEOUT_EN
        n = 0;
        while (imem_req_out && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", n, 16);
        chk("fault_set", fault_out, 1);
        repeat (5) @(negedge clk);
        chk("fault_sticky", fault_out, 1);
        chk("halt_idle", {imem_req_out, dmem_req_out, reg_we_out, alu_cmd_out}, 0);
        reset = 1'b1;
        #1;
        chk("fault_clear", fault_out, 0);
        @(negedge clk);
        reset = 1'b0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
